// File: rtl/c_pc.sv
// Hack program counter: per-bit hold cells fed by a clr > stall > load > inc priority mux,
// with a ripple half-adder incrementer and a registered wrap pulse.
module c_pc #(
  parameter int unsigned    WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH:0]   carry;
  logic             sel_clr, sel_load, sel_inc;

  // Ripple half-adder chain; the final carry is set only when out_q is all ones.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    assign inc_val[i]   = out_q[i] ^ carry[i];
    assign carry[i + 1] = out_q[i] & carry[i];
  end

  // clr is decoded first so unknowns on en/load/inc cannot leak into the clear path.
  always_comb begin
    sel_clr  = clr;
    sel_load = 1'b0;
    sel_inc  = 1'b0;
    if (!clr && en) begin
      sel_load = load;
      sel_inc  = !load && inc;
    end
  end

  always_comb begin
    out_d = out_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sel_clr) begin
        out_d[i] = RESET_VAL[i];
      end else if (sel_load) begin
        out_d[i] = in[i];
      end else if (sel_inc) begin
        out_d[i] = inc_val[i];
      end else begin
        out_d[i] = out_q[i];
      end
    end
    wrap_d = sel_inc && carry[WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= RESET_VAL;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_c_pc.sv
// Bench for c_pc: directed scenarios pinned with literals, then randomized traffic
// compared every cycle against an arithmetic priority model.
module tb_c_pc;

  localparam int W   = 16;
  localparam int MOD = 1 << W;
  localparam logic [W-1:0] RV = '0;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in = '0;
  logic         clr = 1'b0, load = 1'b0, inc = 1'b0, en = 1'b0;
  logic [W-1:0] out;
  logic         wrap;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_out  = RV;
  logic         m_wrap = 1'b0;

  c_pc #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (in),
    .clr     (clr),
    .load    (load),
    .inc     (inc),
    .en      (en),
    .out     (out),
    .wrap    (wrap)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act_o, input logic act_w,
                       input logic [W-1:0] exp_o, input logic exp_w);
    total++;
    if (act_o !== exp_o || act_w !== exp_w) begin
      bad++;
      $display("FAIL %s @%0t: out=%h wrap=%b expected out=%h wrap=%b",
               name, $time, act_o, act_w, exp_o, exp_w);
    end
  endtask

  // Reference model: first matching rule wins.
  always @(posedge clk) begin
    if (reset_n === 1'b1) begin
      if (clr) begin
        m_out  = RV;
        m_wrap = 1'b0;
      end else if (!en) begin
        m_wrap = 1'b0;
      end else if (load) begin
        m_out  = in;
        m_wrap = 1'b0;
      end else if (inc) begin
        m_wrap = (int'(m_out) == MOD - 1);
        m_out  = W'((int'(m_out) + 1) % MOD);
      end else begin
        m_wrap = 1'b0;
      end
    end
    #1;
    check("model", out, wrap, m_out, m_wrap);
  end

  always @(negedge reset_n) begin
    m_out  = RV;
    m_wrap = 1'b0;
    #1;
    check("async_reset", out, wrap, m_out, m_wrap);
  end

  task automatic step(input logic c, input logic e, input logic l, input logic i,
                      input logic [W-1:0] d);
    @(negedge clk);
    clr = c; en = e; load = l; inc = i; in = d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n = 1'b0;
    #3;
    check("reset_state", out, wrap, 16'h0000, 1'b0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // Async reset mid-cycle from a loaded value, then held across edges.
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h1234);
    check("load_1234", out, wrap, 16'h1234, 1'b0);
    @(negedge clk);
    en = 1'b1; inc = 1'b1; load = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid", out, wrap, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("reset_hold", out, wrap, 16'h0000, 1'b0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    inc = 1'b0;

    // Counting.
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
      check("count", out, wrap, W'(k), 1'b0);
    end

    // Priority: load beats inc, clr beats everything.
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0010);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0ABC);
    check("load_over_inc", out, wrap, 16'h0ABC, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0ABC);
    check("clr_wins", out, wrap, 16'h0000, 1'b0);

    // Stall.
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0007);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 16'h4000);
      check("stall", out, wrap, 16'h0007, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h4000);
    check("stall_release", out, wrap, 16'h0008, 1'b0);

    // Wrap.
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFE);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    check("wrap_ffff", out, wrap, 16'hFFFF, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    check("wrap_pulse", out, wrap, 16'h0000, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check("wrap_clear", out, wrap, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    check("load_ffff_nowrap", out, wrap, 16'hFFFF, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    check("wrap_again", out, wrap, 16'h0000, 1'b1);

    // Unknown controls alongside clr.
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h5555);
    step(1'b1, 1'bx, 1'bx, 1'bx, 16'hxxxx);
    check("clr_with_x", out, wrap, 16'h0000, 1'b0);

    // Randomized traffic with occasional async reset pulses.
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      clr  = ($urandom_range(0, 31) == 0);
      en   = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 9) == 0);
      inc  = ($urandom_range(0, 3) != 0);
      in   = ($urandom_range(0, 2) == 0) ? W'(16'hFFFF - $urandom_range(0, 3)) : W'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
